// File: rtl/pipe_sched_ctrl.sv
// pipe_sched_ctrl: central pipeline sequencer.
// The block merges per-stage stall requests into one stall bus and raises
// flush on MEM-stage exceptions or ERET. It also schedules the PC redirect
// so that the redirect never overlaps an outstanding instruction fetch.
// Optional feature macro: PIPE_SCHED_PERF_EN. It adds the stall_cycles and
// flush_count performance counters. Without the macro both ports are tied
// to 0 and no counter flops exist.
module pipe_sched_ctrl #(
    parameter int PC_W    = 32,
    parameter int STALL_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_exe,
    input  logic               stallreq_mem,
    input  logic               exc_req,
    input  logic [PC_W-1:0]    exc_target,
    input  logic               if_busy,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               redirect_valid,
    output logic [PC_W-1:0]    redirect_pc,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_count
);

    typedef enum logic {RUN, REDIR_WAIT} state_t;

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pend_pc_reg, pend_pc_next;
    logic [STALL_W-1:0] merge_mask;
    logic [STALL_W-1:0] stall_raw;
    logic               flush_raw;
    logic               redirect_raw;
    logic [PC_W-1:0]    redirect_pc_raw;

    // State and pending-target registers. Reset drops any pending redirect.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= RUN;
            pend_pc_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pend_pc_reg <= pend_pc_next;
        end
    end

    // Stall merge: the highest requesting stage stops itself and every stage before it.
    always_comb begin
        merge_mask = '0;
        if (stallreq_mem)      merge_mask = STALL_W'(6'b011111);
        else if (stallreq_exe) merge_mask = STALL_W'(6'b001111);
        else if (stallreq_id)  merge_mask = STALL_W'(6'b000111);
        else if (stallreq_if)  merge_mask = STALL_W'(6'b000011);
    end

    // Next-state logic and raw outputs. Flush overrides all stall requests.
    always_comb begin
        state_next      = state_reg;
        pend_pc_next    = pend_pc_reg;
        stall_raw       = merge_mask;
        flush_raw       = 1'b0;
        redirect_raw    = 1'b0;
        redirect_pc_raw = '0;
        case (state_reg)
            RUN: begin
                if (exc_req) begin
                    flush_raw = 1'b1;
                    stall_raw = '0;
                    if (if_busy) begin
                        // Hold the PC until the fetch in flight drains, then redirect.
                        stall_raw[0] = 1'b1;
                        pend_pc_next = exc_target;
                        state_next   = REDIR_WAIT;
                    end else begin
                        redirect_raw    = 1'b1;
                        redirect_pc_raw = exc_target;
                    end
                end
            end
            REDIR_WAIT: begin
                // Block new fetches and discard the stale fetch that returns.
                if (exc_req) begin
                    flush_raw    = 1'b1;
                    stall_raw    = '0;
                    pend_pc_next = exc_target;
                end
                stall_raw[1:0] = 2'b11;
                if (!if_busy) begin
                    redirect_raw    = 1'b1;
                    redirect_pc_raw = exc_req ? exc_target : pend_pc_reg;
                    state_next      = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // All control outputs are held quiet while reset is asserted.
    always_comb begin
        stall          = resetn ? stall_raw       : '0;
        flush          = resetn & flush_raw;
        redirect_valid = resetn & redirect_raw;
        redirect_pc    = resetn ? redirect_pc_raw : '0;
    end

`ifdef PIPE_SCHED_PERF_EN
    logic [CNT_W-1:0] stall_cycles_reg;
    logic [CNT_W-1:0] flush_count_reg;

    // Performance counters. They wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (stall[0] && !flush) stall_cycles_reg <= stall_cycles_reg + 1'b1;
            if (flush)              flush_count_reg  <= flush_count_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_sched_ctrl.sv
// Testbench for pipe_sched_ctrl. It runs directed literal cases first and
// then randomized traffic. Every cycle the outputs are compared against a
// behavioural model that keeps the pending redirect in a queue.
module tb_pipe_sched_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallreq_if, stallreq_id, stallreq_exe, stallreq_mem;
    logic        exc_req;
    logic [31:0] exc_target;
    logic        if_busy;
    logic [5:0]  stall;
    logic        flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stall_cycles, flush_count;

    int tests = 0;
    int fails = 0;

    pipe_sched_ctrl dut (
        .clk(clk), .resetn(resetn),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_exe(stallreq_exe), .stallreq_mem(stallreq_mem),
        .exc_req(exc_req), .exc_target(exc_target), .if_busy(if_busy),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference, compared on every falling edge.
    logic [31:0] pend_q[$];
    logic [31:0] m_stall_cycles = 0;
    logic [31:0] m_flush_count  = 0;
    initial begin : compare_proc
        logic [5:0]  e_stall;
        logic        e_flush, e_rv;
        logic [31:0] e_pc;
        logic [4:0]  req;
        int          top;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_stall = 0; e_flush = 0; e_rv = 0; e_pc = 0;
            if (resetn) begin
                req = {stallreq_mem, stallreq_exe, stallreq_id, stallreq_if, 1'b0};
                top = 0;
                for (int i = 1; i <= 4; i++) if (req[i]) top = i;
                e_stall = (top == 0) ? 6'd0 : 6'((2 << top) - 1);
                e_flush = exc_req;
                if (exc_req) e_stall = 0;
                if (pend_q.size() != 0) e_stall = e_stall | 6'b000011;
                else if (exc_req && if_busy) e_stall = e_stall | 6'b000001;
                if (!if_busy && (exc_req || pend_q.size() != 0)) begin
                    e_rv = 1;
                    e_pc = exc_req ? exc_target : pend_q[0];
                end
            end
            chk("stall", 64'(stall), 64'(e_stall));
            chk("flush", 64'(flush), 64'(e_flush));
            chk("redirect_valid", 64'(redirect_valid), 64'(e_rv));
            chk("redirect_pc", 64'(redirect_pc), 64'(e_pc));
`ifdef PIPE_SCHED_PERF_EN
            chk("stall_cycles", 64'(stall_cycles), 64'(m_stall_cycles));
            chk("flush_count", 64'(flush_count), 64'(m_flush_count));
`else
            chk("stall_cycles", 64'(stall_cycles), 64'd0);
            chk("flush_count", 64'(flush_count), 64'd0);
`endif
            // Update the model to the state expected after the next rising edge.
            if (!resetn) begin
                pend_q.delete();
                m_stall_cycles = 0;
                m_flush_count  = 0;
            end else begin
                if (e_stall[0] && !e_flush) m_stall_cycles++;
                if (e_flush) m_flush_count++;
                if (!if_busy) pend_q.delete();
                else if (exc_req) begin
                    pend_q.delete();
                    pend_q.push_back(exc_target);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stallreq_if = 0; stallreq_id = 0; stallreq_exe = 0; stallreq_mem = 0;
        exc_req = 0; exc_target = 32'h0; if_busy = 0;
    endtask

    // Stimulus with hand-computed literal expectations, then random traffic.
    initial begin : stim_proc
        resetn = 0;
        idle();
        stallreq_mem = 1; exc_req = 1; exc_target = 32'h1234_5678;
        cyc(); #2;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_rv", 64'(redirect_valid), 64'd0);
        chk("rst_pc", 64'(redirect_pc), 64'd0);
        cyc(); resetn = 1; idle();

        // Stall merge: mem beats id, then both dropped.
        cyc(); stallreq_mem = 1; stallreq_id = 1; #2;
        chk("merge_mem_id", 64'(stall), 64'h1F);
        chk("merge_flush", 64'(flush), 64'd0);
        stallreq_mem = 0; stallreq_id = 0; #1;
        chk("merge_drop", 64'(stall), 64'd0);
        stallreq_exe = 1; #1;
        chk("merge_exe", 64'(stall), 64'h0F);
        stallreq_exe = 0; stallreq_if = 1; #1;
        chk("merge_if", 64'(stall), 64'h03);

        // Immediate redirect when the instruction bus is idle.
        cyc(); idle(); exc_req = 1; exc_target = 32'hBFC00380; stallreq_mem = 1; #2;
        chk("imm_flush", 64'(flush), 64'd1);
        chk("imm_stall", 64'(stall), 64'd0);
        chk("imm_rv", 64'(redirect_valid), 64'd1);
        chk("imm_pc", 64'(redirect_pc), 64'hBFC00380);
        cyc(); idle(); #2;
        chk("imm_after_rv", 64'(redirect_valid), 64'd0);
        chk("imm_after_flush", 64'(flush), 64'd0);

        // Deferred redirect while a fetch is outstanding.
        cyc(); exc_req = 1; exc_target = 32'h80000180; if_busy = 1; #2;
        chk("def_c0_flush", 64'(flush), 64'd1);
        chk("def_c0_stall", 64'(stall), 64'h01);
        chk("def_c0_rv", 64'(redirect_valid), 64'd0);
        for (int c = 1; c <= 2; c++) begin
            cyc(); exc_req = 0; exc_target = 0; #2;
            chk("def_wait_stall", 64'(stall), 64'h03);
            chk("def_wait_rv", 64'(redirect_valid), 64'd0);
        end
        cyc(); if_busy = 0; #2;
        chk("def_c3_rv", 64'(redirect_valid), 64'd1);
        chk("def_c3_pc", 64'(redirect_pc), 64'h80000180);
        cyc(); #2;
        chk("def_run_rv", 64'(redirect_valid), 64'd0);
        chk("def_run_stall", 64'(stall), 64'd0);

        // A newer exception during the wait replaces the pending target.
        cyc(); exc_req = 1; exc_target = 32'h80000180; if_busy = 1;
        cyc(); exc_target = 32'hBFC00380; #2;
        chk("pre_flush", 64'(flush), 64'd1);
        chk("pre_rv", 64'(redirect_valid), 64'd0);
        cyc(); exc_req = 0; exc_target = 0; #2;
        chk("pre_wait_rv", 64'(redirect_valid), 64'd0);
        cyc(); if_busy = 0; #2;
        chk("pre_rv_pulse", 64'(redirect_valid), 64'd1);
        chk("pre_pc", 64'(redirect_pc), 64'hBFC00380);
        cyc(); #2;
        chk("pre_single_pulse", 64'(redirect_valid), 64'd0);

        // Reset in the middle of the wait discards the redirect.
        cyc(); exc_req = 1; exc_target = 32'h80000180; if_busy = 1;
        cyc(); exc_req = 0; resetn = 0;
        cyc(); resetn = 1; if_busy = 0; #2;
        chk("rstwait_rv", 64'(redirect_valid), 64'd0);
        chk("rstwait_stall", 64'(stall), 64'd0);

        // Random traffic, checked by the model on every cycle.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            resetn       = ($urandom_range(0, 63) != 0);
            stallreq_if  = ($urandom_range(0, 3) == 0);
            stallreq_id  = ($urandom_range(0, 3) == 0);
            stallreq_exe = ($urandom_range(0, 3) == 0);
            stallreq_mem = ($urandom_range(0, 3) == 0);
            exc_req      = ($urandom_range(0, 7) == 0);
            exc_target   = $urandom;
            if_busy      = ($urandom_range(0, 1) == 0);
        end
        cyc(); idle(); resetn = 1;
        @(posedge clk); @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
